// File: rtl/ls_jk_bank.sv
// ----------------------------------------------------------------------------
// ls_jk_bank
//
// Bank of CHANNELS negative-edge-triggered J-K flip-flops sharing one clock
// and one asynchronous clear. Drop-in generalisation of the dual 74LS107 with
// a per-channel clock enable and a per-channel synchronous clear. With
// CASCADE=1 the stages form a synchronous binary counter: stage i only sees
// its enable when every lower stage currently reads 1. All stages update on
// the same edge, so there is no ripple delay.
//
// Parameters
//   CHANNELS  number of flip-flops (1..32); bit 0 is the least significant
//   CASCADE   0 = independent channels, 1 = synchronous counter chain
//
// Ports
//   _clk   in   1         clock; state changes on its falling edge
//   _clr   in   1         asynchronous active-low clear of every channel
//   ce     in   CHANNELS  per-channel clock enable, active-high
//   j      in   CHANNELS  J inputs
//   k      in   CHANNELS  K inputs
//   _sclr  in   CHANNELS  per-channel synchronous clear, active-low
//   _spre  in   CHANNELS  per-channel synchronous preset, active-low
//                         (present only when LS_JK_BANK_PRESET_EN is defined)
//   q      out  CHANNELS  flip-flop outputs
//   _q     out  CHANNELS  complement of q, combinational
//   tc     out  1         terminal count: CASCADE=1, q all ones and ce[0]
//
// Configuration macro
//   LS_JK_BANK_PRESET_EN  adds the _spre port; sync clear still beats preset.
// ----------------------------------------------------------------------------
module ls_jk_bank #(
    parameter int CHANNELS = 4,
    parameter int CASCADE  = 0
) (
    input  logic                _clk,
    input  logic                _clr,
    input  logic [CHANNELS-1:0] ce,
    input  logic [CHANNELS-1:0] j,
    input  logic [CHANNELS-1:0] k,
    input  logic [CHANNELS-1:0] _sclr,
`ifdef LS_JK_BANK_PRESET_EN
    input  logic [CHANNELS-1:0] _spre,
`endif
    output logic [CHANNELS-1:0] q,
    output logic [CHANNELS-1:0] _q,
    output logic                tc
);

    logic [CHANNELS-1:0] en;
    logic [CHANNELS-1:0] q_next;

    // Effective enable per stage. In cascade mode the gating term is the AND
    // of all lower q bits as they stand before the edge; j/k of the lower
    // stages play no part, so a held stage sitting at 1 still passes the
    // enable upward.
    always_comb begin : enable_chain
        logic lower_ones;
        // NOTE: blocking '=' is correct here: lower_ones is a running temporary
        // inside combinational logic, and each iteration must see the value
        // updated by the previous one.
        lower_ones = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (CASCADE != 0) begin
                en[i] = ce[i] & lower_ones;
            end else begin
                en[i] = ce[i];
            end
            lower_ones = lower_ones & q[i];
        end
    end

    // Per-channel next state: sync clear, then sync preset, then enable,
    // then the J-K table.
    always_comb begin
        // NOTE: q_next gets a full default before the loop so every path
        // assigns it; without this the hold cases would infer latches.
        q_next = q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!_sclr[i]) begin
                q_next[i] = 1'b0;
            end
`ifdef LS_JK_BANK_PRESET_EN
            else if (!_spre[i]) begin
                q_next[i] = 1'b1;
            end
`endif
            else if (en[i]) begin
                case ({j[i], k[i]})
                    2'b10:   q_next[i] = 1'b1;
                    2'b01:   q_next[i] = 1'b0;
                    2'b11:   q_next[i] = ~q[i];
                    default: q_next[i] = q[i];
                endcase
            end
        end
    end

    // NOTE: _clr is in the sensitivity list, so it clears q the moment it
    // falls, without waiting for a clock edge, and holds q at zero while low.
    always_ff @(negedge _clk or negedge _clr) begin
        if (!_clr) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

    assign _q = ~q;
    assign tc = (CASCADE != 0) && (&q) && ce[0];

endmodule

// File: tb/tb_ls_jk_bank.sv
// ----------------------------------------------------------------------------
// tb_ls_jk_bank
//
// Directed bench for ls_jk_bank with CHANNELS=4. Two instances share the
// clock and asynchronous clear: u_ind (CASCADE=0) and u_cnt (CASCADE=1).
// Inputs change 1 ns after each falling edge; outputs are checked at the
// same point, well clear of the next active edge.
// ----------------------------------------------------------------------------
module tb_ls_jk_bank;

    localparam int N = 4;

    logic         clk;
    logic         clr_n;

    logic [N-1:0] ind_ce, ind_j, ind_k, ind_sclr_n, ind_spre_n;
    logic [N-1:0] ind_q, ind_qn;
    logic         ind_tc;

    logic [N-1:0] cnt_ce, cnt_j, cnt_k, cnt_sclr_n, cnt_spre_n;
    logic [N-1:0] cnt_q, cnt_qn;
    logic         cnt_tc;

    int tests_run    = 0;
    int tests_failed = 0;

    ls_jk_bank #(.CHANNELS(N), .CASCADE(0)) u_ind (
        ._clk  (clk),
        ._clr  (clr_n),
        .ce    (ind_ce),
        .j     (ind_j),
        .k     (ind_k),
        ._sclr (ind_sclr_n),
`ifdef LS_JK_BANK_PRESET_EN
        ._spre (ind_spre_n),
`endif
        .q     (ind_q),
        ._q    (ind_qn),
        .tc    (ind_tc)
    );

    ls_jk_bank #(.CHANNELS(N), .CASCADE(1)) u_cnt (
        ._clk  (clk),
        ._clr  (clr_n),
        .ce    (cnt_ce),
        .j     (cnt_j),
        .k     (cnt_k),
        ._sclr (cnt_sclr_n),
`ifdef LS_JK_BANK_PRESET_EN
        ._spre (cnt_spre_n),
`endif
        .q     (cnt_q),
        ._q    (cnt_qn),
        .tc    (cnt_tc)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next falling (active) edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset held, inputs active ----------------
        clr_n      = 1'b0;
        ind_ce     = 4'b1111; ind_j = 4'b1111; ind_k = 4'b1111;
        ind_sclr_n = 4'b1111; ind_spre_n = 4'b1111;
        cnt_ce     = 4'b0000; cnt_j = 4'b1111; cnt_k = 4'b1111;
        cnt_sclr_n = 4'b1111; cnt_spre_n = 4'b1111;
        tick();
        tick();
        check("rst_hold_q", 32'(ind_q), 32'h0);
        check("rst_hold_qn", 32'(ind_qn), 32'hf);
        check("rst_hold_cnt_tc", 32'(cnt_tc), 32'h0);

        // ---------------- release, no edge yet ----------------
        ind_ce = 4'b0000;
        clr_n  = 1'b1;
        #1;
        check("rel_q", 32'(ind_q), 32'h0);
        check("rel_qn", 32'(ind_qn), 32'hf);
        check("rel_tc", 32'(ind_tc), 32'h0);
        check("rel_cnt_q", 32'(cnt_q), 32'h0);

        // ---------------- J-K table, one edge ----------------
        ind_j = 4'b1010; ind_k = 4'b0110; ind_ce = 4'b1111;
        tick();
        check("jk_table_q", 32'(ind_q), 32'ha);
        check("jk_table_qn", 32'(ind_qn), 32'h5);

        // ---------------- enables off for 5 edges ----------------
        ind_ce = 4'b0000; ind_j = 4'b1111; ind_k = 4'b1111;
        for (int n = 0; n < 5; n++) tick();
        check("ce_off_hold", 32'(ind_q), 32'ha);

        ind_ce = 4'b0001;
        tick();
        check("ce0_toggle_a", 32'(ind_q), 32'hb);
        tick();
        check("ce0_toggle_b", 32'(ind_q), 32'ha);

        // ---------------- all ones, tc tied low when CASCADE=0 ----------------
        ind_ce = 4'b1111; ind_j = 4'b1111; ind_k = 4'b0000;
        tick();
        check("ind_all_ones", 32'(ind_q), 32'hf);
        check("ind_tc_zero", 32'(ind_tc), 32'h0);

        // ---------------- sync clear ignores ce ----------------
        ind_ce = 4'b0000; ind_sclr_n = 4'b0101;
        tick();
        check("sclr_ind", 32'(ind_q), 32'h5);

        // ---------------- j=k=0 holds with ce high ----------------
        ind_sclr_n = 4'b1111; ind_ce = 4'b1111; ind_j = 4'b0000; ind_k = 4'b0000;
        tick();
        check("jk00_hold", 32'(ind_q), 32'h5);

        // ---------------- cascade: full count and wrap ----------------
        cnt_ce = 4'b1111; cnt_j = 4'b1111; cnt_k = 4'b1111;
        #1;
        for (int n = 0; n < 16; n++) begin
            check($sformatf("count_q_%0d", n), 32'(cnt_q), 32'(n));
            check($sformatf("count_tc_%0d", n), 32'(cnt_tc), (n == 15) ? 32'h1 : 32'h0);
            tick();
        end
        check("count_wrap", 32'(cnt_q), 32'h0);

        // ---------------- cascade at 0111 with bit0 sync clear ----------------
        for (int n = 0; n < 7; n++) tick();
        check("count_at_7", 32'(cnt_q), 32'h7);
        cnt_sclr_n = 4'b1110;
        tick();
        check("sclr_pre_edge_en", 32'(cnt_q), 32'h8);
        cnt_sclr_n = 4'b1111;

        // ---------------- lower stage held by j=k=0 still gates upward ----------------
        tick();
        check("count_at_9", 32'(cnt_q), 32'h9);
        cnt_j = 4'b1110; cnt_k = 4'b1110;
        tick();
        check("held_gate_a", 32'(cnt_q), 32'hb);
        tick();
        check("held_gate_b", 32'(cnt_q), 32'hd);

        // ---------------- tc depends on ce[0] ----------------
        cnt_j = 4'b1111; cnt_k = 4'b0000;
        tick();
        check("set_all_ones", 32'(cnt_q), 32'hf);
        check("tc_ce0_high", 32'(cnt_tc), 32'h1);
        cnt_ce = 4'b1110;
        #1;
        check("tc_ce0_low", 32'(cnt_tc), 32'h0);
        cnt_ce = 4'b1111; cnt_j = 4'b1111; cnt_k = 4'b1111;
        tick();
        check("wrap_from_ones", 32'(cnt_q), 32'h0);

        // ---------------- async clear mid-count ----------------
        for (int n = 0; n < 3; n++) tick();
        check("count_at_3", 32'(cnt_q), 32'h3);
        #2;
        clr_n = 1'b0;
        #1;
        check("async_clr_q", 32'(cnt_q), 32'h0);
        check("async_clr_qn", 32'(cnt_qn), 32'hf);
        check("async_clr_tc", 32'(cnt_tc), 32'h0);
        #1;
        clr_n = 1'b1;
        tick();
        check("restart_count", 32'(cnt_q), 32'h1);

`ifdef LS_JK_BANK_PRESET_EN
        // ---------------- preset vs sync clear ----------------
        clr_n = 1'b0;
        #1;
        clr_n = 1'b1;
        ind_ce = 4'b0000; ind_spre_n = 4'b1010; ind_sclr_n = 4'b1110;
        tick();
        check("preset_vs_clear", 32'(ind_q), 32'h4);
        ind_spre_n = 4'b1111; ind_sclr_n = 4'b1111;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
